// File: rtl/imem_boot_loader.sv
// Boot loader: unpacks a length-prefixed, XOR-checked byte stream into 32-bit
// little-endian instruction-memory writes and releases the core once the image checks out.
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned CAP   = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    logic [15:0]      len;
    logic [CNT_W-1:0] word_cnt;
    logic [1:0]       byte_idx;
    logic [7:0]       chk;
    logic [23:0]      lanes;

    logic             xfer;
    logic [15:0]      new_len;
    logic             last_word;

    assign xfer      = in_valid & in_ready;
    assign new_len   = {in_data, len[7:0]};
    // word_cnt is one wider than the address so a full-memory image can be counted
    assign last_word = (32'(word_cnt) + 32'd1) == 32'(len);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_LEN_LO;
            len        <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            chk        <= '0;
            lanes      <= '0;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= in_data;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= in_data;
                        if (32'(new_len) > CAP) begin
                            state    <= S_ERR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (new_len == 16'd0) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        chk      <= chk ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    lanes[7:0]   <= in_data;
                            2'd1:    lanes[15:8]  <= in_data;
                            2'd2:    lanes[23:16] <= in_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_cnt[ADDR_W-1:0];
                                imem_wdata <= {in_data, lanes};
                                word_cnt   <= word_cnt + CNT_W'(1);
                                if (last_word) begin
                                    state <= S_CHK;
                                end
                            end
                        endcase
                    end
                end
                S_CHK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == chk) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    // restart clears frame bookkeeping; memory contents are kept
                    if (start) begin
                        state    <= S_LEN_LO;
                        len      <= '0;
                        word_cnt <= '0;
                        byte_idx <= '0;
                        chk      <= '0;
                        in_ready <= 1'b1;
                        core_rst <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                default: begin
                    state <= S_LEN_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table-driven frames, randomized frames with gaps,
// and hand sequences for reset/start corner cases, all against a frame-level model.
module tb_imem_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        start;
    logic [7:0]  in_data;

    logic        ready_m, we_m, crst_m, done_m, err_m;
    logic [9:0]  addr_m;
    logic [31:0] wdata_m;
    logic        ready_s, we_s, crst_s, done_s, err_s;
    logic [1:0]  addr_s;
    logic [31:0] wdata_s;

    imem_boot_loader #(.ADDR_W(10)) u_main (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ready_m), .start(start), .imem_we(we_m), .imem_addr(addr_m),
        .imem_wdata(wdata_m), .core_rst(crst_m), .done(done_m), .error(err_m)
    );

    imem_boot_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(ready_s), .start(start), .imem_we(we_s), .imem_addr(addr_s),
        .imem_wdata(wdata_s), .core_rst(crst_s), .done(done_s), .error(err_s)
    );

    // sel picks which instance the bench is currently driving and observing
    bit          sel;
    logic        c_ready, c_we, c_crst, c_done, c_err;
    logic [31:0] c_addr, c_wdata;
    assign c_ready = sel ? ready_s : ready_m;
    assign c_we    = sel ? we_s    : we_m;
    assign c_crst  = sel ? crst_s  : crst_m;
    assign c_done  = sel ? done_s  : done_m;
    assign c_err   = sel ? err_s   : err_m;
    assign c_addr  = sel ? 32'(addr_s) : 32'(addr_m);
    assign c_wdata = sel ? wdata_s : wdata_m;

    logic [63:0] got[$];
    logic [7:0]  fq[$];
    logic [31:0] exp_words[$];
    int unsigned exp_consumed;
    bit          exp_done, exp_err;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(negedge clk) begin
        if (c_we) got.push_back({c_addr, c_wdata});
    end

    typedef struct packed {
        logic        sm;
        logic [31:0] n;
        logic [191:0] frame;
        logic        done;
        logic        err;
        logic [31:0] nw;
        logic [31:0] w_last;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic sm, input int n, input logic [191:0] f,
                                input logic d, input logic e, input int nw, input logic [31:0] wl);
        vec_t v;
        v.sm = sm; v.n = 32'(n); v.frame = f; v.done = d; v.err = e;
        v.nw = 32'(nw); v.w_last = wl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Frame-level reference: decode length, slice words, XOR payload, compare.
    function automatic void model(input int unsigned cap);
        int unsigned ln;
        logic [7:0]  x;
        x = 8'h00;
        exp_words.delete();
        ln = 32'({fq[1], fq[0]});
        if (ln > cap) begin
            exp_consumed = 2; exp_done = 1'b0; exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < int'(ln); i++)
            exp_words.push_back({fq[2+4*i+3], fq[2+4*i+2], fq[2+4*i+1], fq[2+4*i]});
        for (int i = 0; i < int'(4*ln); i++)
            x = x ^ fq[2+i];
        exp_consumed = 3 + 4*ln;
        exp_done = (fq[exp_consumed-1] == x);
        exp_err  = !exp_done;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        got.delete();
        @(negedge clk);
        check("rst_done", 32'(c_done), 32'd0);
        check("rst_error", 32'(c_err), 32'd0);
        check("rst_core_rst", 32'(c_crst), 32'd1);
        check("rst_in_ready", 32'(c_ready), 32'd1);
        check("rst_we", 32'(c_we), 32'd0);
        check("rst_addr", c_addr, 32'd0);
        check("rst_wdata", c_wdata, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n;
        n = 0; ok = 1'b0;
        in_valid = 1'b1; in_data = b;
        while (n < 50 && !ok) begin
            @(negedge clk);
            if (c_ready) ok = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int from, input int to, input int max_gap);
        bit ok;
        int g;
        for (int i = from; i < to; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) begin @(posedge clk); #1; end
            send_byte(fq[i], ok);
            if (!ok) begin
                n_chk++; n_fail++;
                $display("FAIL byte_accept: byte %0d not accepted within 50 cycles", i);
                return;
            end
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        int m;
        check({tag, "_nwrites"}, 32'(got.size()), 32'(exp_words.size()));
        m = (got.size() < exp_words.size()) ? got.size() : exp_words.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_addr%0d", tag, i), got[i][63:32], 32'(i));
            check($sformatf("%s_data%0d", tag, i), got[i][31:0], exp_words[i]);
        end
        check({tag, "_done"}, 32'(c_done), 32'(exp_done));
        check({tag, "_error"}, 32'(c_err), 32'(exp_err));
        check({tag, "_core_rst"}, 32'(c_crst), 32'(!exp_done));
        check({tag, "_in_ready"}, 32'(c_ready), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_core_rst", 32'(c_crst), 32'd1);
        check("start_done", 32'(c_done), 32'd0);
        check("start_error", 32'(c_err), 32'd0);
        check("start_in_ready", 32'(c_ready), 32'd1);
        got.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; start = 1'b0; in_data = 8'h00; sel = 1'b0;

        // payload 13 00 00 00 93 00 10 00 XORs to 0x90
        vecs[0]  = mk(1'b0, 11, 192'h0200_13000000_93001000_90, 1'b1, 1'b0, 2, 32'h00100093);
        vecs[1]  = mk(1'b0, 11, 192'h0200_13000000_93001000_80, 1'b0, 1'b1, 2, 32'h00100093);
        vecs[2]  = mk(1'b0, 11, 192'h0200_13000000_93001000_81, 1'b0, 1'b1, 2, 32'h00100093);
        vecs[3]  = mk(1'b0, 3,  192'h0000_00, 1'b1, 1'b0, 0, 32'h0);
        vecs[4]  = mk(1'b0, 3,  192'h0000_01, 1'b0, 1'b1, 0, 32'h0);
        vecs[5]  = mk(1'b0, 7,  192'h0100_efbeadde_22, 1'b1, 1'b0, 1, 32'hdeadbeef);
        vecs[6]  = mk(1'b0, 2,  192'h0104, 1'b0, 1'b1, 0, 32'h0);
        vecs[7]  = mk(1'b1, 2,  192'h0500, 1'b0, 1'b1, 0, 32'h0);
        vecs[8]  = mk(1'b1, 2,  192'h0001, 1'b0, 1'b1, 0, 32'h0);
        vecs[9]  = mk(1'b1, 19, 192'h0400_01020304_05060708_090a0b0c_0d0e0f10_10,
                      1'b1, 1'b0, 4, 32'h100f0e0d);
        vecs[10] = mk(1'b1, 7,  192'h0100_aa55aa55_00, 1'b1, 1'b0, 1, 32'h55aa55aa);

        for (int i = 0; i < NV; i++) begin
            sel = vecs[i].sm;
            do_reset();
            fq.delete();
            for (int k = 0; k < int'(vecs[i].n); k++)
                fq.push_back(vecs[i].frame[8*(int'(vecs[i].n)-1-k) +: 8]);
            model(sel ? 32'd4 : 32'd1024);
            send_range(0, int'(exp_consumed), 0);
            settle();
            check($sformatf("v%0d_done", i), 32'(c_done), 32'(vecs[i].done));
            check($sformatf("v%0d_error", i), 32'(c_err), 32'(vecs[i].err));
            check($sformatf("v%0d_nw", i), 32'(got.size()), vecs[i].nw);
            if (vecs[i].nw != 0 && got.size() != 0)
                check($sformatf("v%0d_wlast", i), got[got.size()-1][31:0], vecs[i].w_last);
            check_frame($sformatf("v%0d", i));
        end

        // randomized frames with in_valid gaps; t=0 and t=1 are the same image
        sel = 1'b0;
        do_reset();
        for (int t = 0; t < 20; t++) begin
            int unsigned ln;
            logic [7:0]  x;
            logic [7:0]  b;
            bit          bad;
            ln = (t < 2) ? 32'd4 : $urandom_range(1, 8);
            x = 8'h00;
            fq.delete();
            fq.push_back(ln[7:0]);
            fq.push_back(ln[15:8]);
            for (int k = 0; k < int'(4*ln); k++) begin
                b = (t < 2) ? 8'(17*k + 3) : 8'($urandom);
                fq.push_back(b);
                x = x ^ b;
            end
            bad = (t >= 2) && ($urandom_range(0, 3) == 0);
            fq.push_back(bad ? (x ^ 8'h01) : x);
            model(32'd1024);
            send_range(0, int'(exp_consumed), (t == 0) ? 0 : 3);
            settle();
            check_frame($sformatf("r%0d", t));
            pulse_start();
        end

        // reset after two payload words, then a one-word frame rewrites only addr0
        do_reset();
        fq.delete();
        fq.push_back(8'h03); fq.push_back(8'h00);
        for (int k = 0; k < 12; k++) fq.push_back(8'(k + 1));
        fq.push_back(8'h00);
        send_range(0, 10, 0);
        settle();
        check("abort_nwrites", 32'(got.size()), 32'd2);
        do_reset();
        fq.delete();
        fq.push_back(8'h01); fq.push_back(8'h00);
        fq.push_back(8'hef); fq.push_back(8'hbe); fq.push_back(8'had); fq.push_back(8'hde);
        fq.push_back(8'h22);
        model(32'd1024);
        send_range(0, int'(exp_consumed), 1);
        settle();
        check_frame("after_abort");

        // start with a byte offered in DONE: byte must not be taken
        in_valid = 1'b1; in_data = 8'h00; start = 1'b1;
        @(negedge clk);
        check("start_valid_in_ready", 32'(c_ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
        check("restart_core_rst", 32'(c_crst), 32'd1);
        check("restart_done", 32'(c_done), 32'd0);
        check("restart_in_ready", 32'(c_ready), 32'd1);
        got.delete();
        fq.delete();
        fq.push_back(8'h00); fq.push_back(8'h00); fq.push_back(8'h00);
        model(32'd1024);
        send_range(0, int'(exp_consumed), 0);
        settle();
        check_frame("restart");

        // start pulse mid-frame is ignored
        pulse_start();
        fq.delete();
        fq.push_back(8'h02); fq.push_back(8'h00);
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
        fq.push_back(8'h55); fq.push_back(8'h66); fq.push_back(8'h77); fq.push_back(8'h88);
        fq.push_back(8'h88);
        model(32'd1024);
        send_range(0, 4, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_range(4, int'(exp_consumed), 0);
        settle();
        check_frame("mid_start");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
